// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter
// Brief    : Round-robin two-client arbiter and sequencer for a shared LIFO.
// Revision : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
    parameter int WordSize    = 4,
    parameter int AddressSize = 3
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic                Req0,
    input  logic                Req1,
    input  logic                Op0,
    input  logic                Op1,
    input  logic [WordSize-1:0] Din0,
    input  logic [WordSize-1:0] Din1,
    output logic                Ack0,
    output logic                Ack1,
    output logic                Nack0,
    output logic                Nack1,
    output logic [WordSize-1:0] Dout0,
    output logic [WordSize-1:0] Dout1,
    output logic                Busy,
    output logic                S_Push,
    output logic                S_Pop,
    output logic [WordSize-1:0] S_Data_In,
    input  logic [WordSize-1:0] S_Data_Out,
    input  logic                S_Full,
    input  logic                S_Empty
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [AddressSize:0] c_DEPTH = (AddressSize + 1)'(1 << AddressSize);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_prio;
    logic                  r_win;
    logic                  r_op;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_nack0;
    logic                  r_nack1;
    logic                  r_s_push;
    logic                  r_s_pop;
    logic [WordSize-1:0]   r_s_data_in;
    logic [WordSize-1:0]   r_dout0;
    logic [WordSize-1:0]   r_dout1;
    logic [AddressSize:0]  r_level;

    logic                  w_any;
    logic                  w_grant;
    logic                  w_gop;
    logic                  w_reject;
    logic [WordSize-1:0]   w_gdin;

    always_comb begin
        w_any    = Req0 | Req1;
        // With both requesting, the pointer names the client not served last.
        w_grant  = (Req0 && Req1) ? r_prio : Req1;
        w_gop    = w_grant ? Op1 : Op0;
        w_gdin   = w_grant ? Din1 : Din0;
        w_reject = w_gop ? S_Full : S_Empty;
    end

    always_ff @(posedge Clk) begin
        if (RstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next_state = w_reject ? RESP : ISSUE;
                end
            end
            ISSUE:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RstN) begin
            r_prio      <= 1'b0;
            r_win       <= 1'b0;
            r_op        <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_nack0     <= 1'b0;
            r_nack1     <= 1'b0;
            r_s_push    <= 1'b0;
            r_s_pop     <= 1'b0;
            r_s_data_in <= '0;
            r_dout0     <= '0;
            r_dout1     <= '0;
            r_level     <= '0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_nack0     <= 1'b0;
            r_nack1     <= 1'b0;
            r_s_push    <= 1'b0;
            r_s_pop     <= 1'b0;
            r_s_data_in <= '0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win <= w_grant;
                        r_op  <= w_gop;
                        if (w_reject) begin
                            r_nack0 <= ~w_grant;
                            r_nack1 <= w_grant;
                        end else begin
                            r_s_push    <= w_gop;
                            r_s_pop     <= ~w_gop;
                            r_s_data_in <= w_gdin;
                        end
                    end
                end
                CAPTURE: begin
                    if (!r_op) begin
                        if (r_win) begin
                            r_dout1 <= S_Data_Out;
                        end else begin
                            r_dout0 <= S_Data_Out;
                        end
                    end
                    r_ack0 <= ~r_win;
                    r_ack1 <= r_win;
                end
                RESP: begin
                    r_prio <= ~r_win;
                end
                default: begin
                end
            endcase

            // Shadow occupancy, used only to cross-check the stack flags.
            if (r_s_push) begin
                r_level <= r_level + 1'b1;
            end else if (r_s_pop) begin
                r_level <= r_level - 1'b1;
            end

            if (r_state == IDLE) begin
                assert (S_Full == (r_level == c_DEPTH));
                assert (S_Empty == (r_level == '0));
            end
            assert (!(r_s_push && r_s_pop));
        end
    end

    assign Busy      = (r_state != IDLE);
    assign Ack0      = r_ack0;
    assign Ack1      = r_ack1;
    assign Nack0     = r_nack0;
    assign Nack1     = r_nack1;
    assign S_Push    = r_s_push;
    assign S_Pop     = r_s_pop;
    assign S_Data_In = r_s_data_in;
    assign Dout0     = r_dout0;
    assign Dout1     = r_dout1;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// Self-checking bench for stack_arbiter: attached 8-deep LIFO plus an
// abstract queue-based model of arbitration and stack contents.
module tb_stack_arbiter;

    localparam int DEPTH = 8;

    logic       Clk;
    logic       RstN;
    logic       Req0, Req1, Op0, Op1;
    logic [3:0] Din0, Din1;
    logic       Ack0, Ack1, Nack0, Nack1;
    logic [3:0] Dout0, Dout1;
    logic       Busy, S_Push, S_Pop;
    logic [3:0] S_Data_In;
    logic [3:0] S_Data_Out;
    logic       S_Full, S_Empty;

    int n_vec = 0;
    int n_err = 0;

    stack_arbiter #(.WordSize(4), .AddressSize(3)) dut (
        .Clk(Clk), .RstN(RstN),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .Din0(Din0), .Din1(Din1),
        .Ack0(Ack0), .Ack1(Ack1), .Nack0(Nack0), .Nack1(Nack1),
        .Dout0(Dout0), .Dout1(Dout1), .Busy(Busy),
        .S_Push(S_Push), .S_Pop(S_Pop), .S_Data_In(S_Data_In),
        .S_Data_Out(S_Data_Out), .S_Full(S_Full), .S_Empty(S_Empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Attached stack: registered pop data, reset shares RstN.
    logic [3:0] stk_mem [DEPTH];
    logic [3:0] stk_cnt = 4'd0;
    logic [3:0] stk_top;
    assign stk_top = stk_cnt - 4'd1;
    always @(posedge Clk) begin
        if (RstN) begin
            stk_cnt    <= 4'd0;
            S_Data_Out <= 4'd0;
        end else if (S_Push && stk_cnt < 4'd8) begin
            stk_mem[stk_cnt[2:0]] <= S_Data_In;
            stk_cnt <= stk_cnt + 4'd1;
        end else if (S_Pop && stk_cnt > 4'd0) begin
            S_Data_Out <= stk_mem[stk_top[2:0]];
            stk_cnt <= stk_cnt - 4'd1;
        end
    end
    assign S_Full  = (stk_cnt == 4'd8);
    assign S_Empty = (stk_cnt == 4'd0);

    // Reference model
    logic [3:0] ref_q[$];
    bit         ref_prio;
    logic [3:0] ref_dout [2];

    task automatic model_reset();
        ref_q.delete();
        ref_prio    = 1'b0;
        ref_dout[0] = 4'd0;
        ref_dout[1] = 4'd0;
    endtask

    task automatic model_txn(input bit r0, input bit r1, input bit o0, input bit o1,
                             input logic [3:0] d0, input logic [3:0] d1,
                             output int win, output bit ok, output bit op);
        logic [3:0] d;
        win = (r0 && r1) ? int'(ref_prio) : (r1 ? 1 : 0);
        op  = (win == 1) ? o1 : o0;
        d   = (win == 1) ? d1 : d0;
        ok  = 1'b0;
        if (op) begin
            if (ref_q.size() < DEPTH) begin
                ref_q.push_back(d);
                ok = 1'b1;
            end
        end else if (ref_q.size() > 0) begin
            ref_dout[win] = ref_q.pop_back();
            ok = 1'b1;
        end
        ref_prio = (win == 0);
    endtask

    function automatic logic [3:0] exp_vec(input int win, input bit ok);
        if (ok) return (win == 1) ? 4'b0100 : 4'b1000;
        return (win == 1) ? 4'b0001 : 4'b0010;
    endfunction

    // Advance from an IDLE negedge until a response pulse, bounded.
    task automatic wait_resp(output int lat, output logic [3:0] vec,
                             output int npush, output int npop, output logic [3:0] sdin);
        lat = -1; vec = 4'd0; npush = 0; npop = 0; sdin = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk); @(negedge Clk);
            if (S_Push) begin npush++; sdin = S_Data_In; end
            if (S_Pop) npop++;
            if ({Ack0, Ack1, Nack0, Nack1} != 4'd0) begin
                vec = {Ack0, Ack1, Nack0, Nack1};
                lat = c;
                break;
            end
        end
    endtask

    task automatic exec(input bit r0, input bit r1, input bit o0, input bit o1,
                        input logic [3:0] d0, input logic [3:0] d1,
                        output int win, output bit ok, output bit op, output int lat,
                        output logic [3:0] vec, output int npush, output int npop,
                        output logic [3:0] sdin);
        Req0 = r0; Req1 = r1; Op0 = o0; Op1 = o1; Din0 = d0; Din1 = d1;
        model_txn(r0, r1, o0, o1, d0, d1, win, ok, op);
        wait_resp(lat, vec, npush, npop, sdin);
    endtask

    task automatic release_reqs();
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic do_reset();
        RstN = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clk); @(negedge Clk);
        RstN = 1'b0;
        model_reset();
        @(posedge Clk); @(negedge Clk);
    endtask

    int win, lat, npush, npop;
    bit ok, op;
    logic [3:0] vec, sdin;

    task automatic test_reset();
        RstN = 1'b1; Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; Din0 = 0; Din1 = 0;
        @(posedge Clk); @(negedge Clk);
        n_vec++; if ({Busy, Ack0, Ack1, Nack0, Nack1, S_Push, S_Pop} !== 7'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000000", {Busy, Ack0, Ack1, Nack0, Nack1, S_Push, S_Pop}); end
        n_vec++; if ({S_Data_In, Dout0, Dout1} !== 12'h000) begin
            n_err++; $display("FAIL reset_data: got %h want 000", {S_Data_In, Dout0, Dout1}); end
        RstN = 1'b0;
        model_reset();
        @(posedge Clk); @(negedge Clk);
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", Busy); end
    endtask

    task automatic test_single_push_pop();
        exec(1, 0, 1, 0, 4'hA, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL push_latency: got %0d want 3", lat); end
        n_vec++; if (vec !== exp_vec(win, ok)) begin n_err++; $display("FAIL push_resp: got %b want %b", vec, exp_vec(win, ok)); end
        n_vec++; if (npush !== 1 || npop !== 0) begin n_err++; $display("FAIL push_strobes: got push=%0d pop=%0d want 1/0", npush, npop); end
        n_vec++; if (sdin !== 4'hA) begin n_err++; $display("FAIL push_data: got %h want a", sdin); end
        release_reqs();
        exec(0, 1, 0, 0, 4'h0, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (vec !== exp_vec(win, ok) || lat !== 3) begin
            n_err++; $display("FAIL pop1_resp: got %b lat %0d want %b lat 3", vec, lat, exp_vec(win, ok)); end
        n_vec++; if (Dout1 !== ref_dout[1]) begin n_err++; $display("FAIL pop1_data: got %h want %h", Dout1, ref_dout[1]); end
        n_vec++; if (S_Empty !== 1'b1 || npop !== 1) begin
            n_err++; $display("FAIL pop1_empty: got empty=%b pops=%0d want 1/1", S_Empty, npop); end
        release_reqs();
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            exec(1, 1, 1, 1, 4'h1, 4'h2, win, ok, op, lat, vec, npush, npop, sdin);
            n_vec++; if (vec !== exp_vec(win, ok) || lat !== 3) begin
                n_err++; $display("FAIL cont_push%0d: got %b lat %0d want %b lat 3", i, vec, lat, exp_vec(win, ok)); end
            n_vec++; if (sdin !== ((win == 1) ? 4'h2 : 4'h1)) begin
                n_err++; $display("FAIL cont_push_data%0d: got %h want %h", i, sdin, (win == 1) ? 4'h2 : 4'h1); end
            if (i < 3) begin @(posedge Clk); @(negedge Clk); end
        end
        release_reqs();
        for (int i = 0; i < 4; i++) begin
            exec(1, 1, 0, 0, 4'h0, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
            n_vec++; if (vec !== exp_vec(win, ok)) begin
                n_err++; $display("FAIL cont_pop%0d: got %b want %b", i, vec, exp_vec(win, ok)); end
            n_vec++; if (Dout0 !== ref_dout[0] || Dout1 !== ref_dout[1]) begin
                n_err++; $display("FAIL cont_pop_data%0d: got %h/%h want %h/%h", i, Dout0, Dout1, ref_dout[0], ref_dout[1]); end
            if (i < 3) begin @(posedge Clk); @(negedge Clk); end
        end
        release_reqs();
    endtask

    task automatic test_full_reject();
        do_reset();
        for (int v = 0; v < 8; v++) begin
            exec(1, 0, 1, 0, 4'(v), 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
            n_vec++; if (vec !== exp_vec(win, ok)) begin
                n_err++; $display("FAIL fill%0d: got %b want %b", v, vec, exp_vec(win, ok)); end
            release_reqs();
        end
        exec(1, 0, 1, 0, 4'hF, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (vec !== 4'b0010 || lat !== 1) begin
            n_err++; $display("FAIL full_nack: got %b lat %0d want 0010 lat 1", vec, lat); end
        n_vec++; if (npush !== 0) begin n_err++; $display("FAIL full_nopush: got %0d want 0", npush); end
        release_reqs();
        exec(0, 1, 0, 0, 4'h0, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (Dout1 !== 4'h7 || vec !== 4'b0100) begin
            n_err++; $display("FAIL full_pop: got %h resp %b want 7 resp 0100", Dout1, vec); end
        release_reqs();
    endtask

    task automatic test_empty_reject();
        do_reset();
        exec(1, 0, 0, 0, 4'h0, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (vec !== 4'b0010 || lat !== 1) begin
            n_err++; $display("FAIL empty_nack: got %b lat %0d want 0010 lat 1", vec, lat); end
        n_vec++; if (npop !== 0 || Dout0 !== 4'h0) begin
            n_err++; $display("FAIL empty_nopop: got pops=%0d dout=%h want 0/0", npop, Dout0); end
        release_reqs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        Req0 = 1'b1; Op0 = 1'b1; Din0 = 4'h3;
        @(posedge Clk); @(negedge Clk);
        n_vec++; if (S_Push !== 1'b1) begin n_err++; $display("FAIL midrst_issue: got %b want 1", S_Push); end
        RstN = 1'b1; Req0 = 1'b0;
        @(posedge Clk); @(negedge Clk);
        n_vec++; if ({Busy, S_Push, S_Pop, Ack0, Ack1, Nack0, Nack1} !== 7'd0 || S_Empty !== 1'b1) begin
            n_err++; $display("FAIL midrst_state: got %b empty=%b want 0000000 empty=1",
                              {Busy, S_Push, S_Pop, Ack0, Ack1, Nack0, Nack1}, S_Empty); end
        RstN = 1'b0;
        model_reset();
        @(posedge Clk); @(negedge Clk);
        exec(1, 0, 0, 0, 4'h0, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        n_vec++; if (vec !== 4'b0010) begin n_err++; $display("FAIL midrst_pop: got %b want 0010", vec); end
        release_reqs();
    endtask

    task automatic test_req_drop();
        int activity;
        do_reset();
        exec(1, 0, 1, 0, 4'h5, 4'h0, win, ok, op, lat, vec, npush, npop, sdin);
        release_reqs();
        Req0 = 1'b1; Op0 = 1'b0;
        model_txn(1, 0, 0, 0, 4'h0, 4'h0, win, ok, op);
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        Req0 = 1'b0;
        @(posedge Clk); @(negedge Clk);
        n_vec++; if (Ack0 !== 1'b1 || Dout0 !== 4'h5) begin
            n_err++; $display("FAIL drop_ack: got ack=%b dout=%h want 1/5", Ack0, Dout0); end
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); @(negedge Clk);
            if (Busy || S_Push || S_Pop || Ack0 || Ack1 || Nack0 || Nack1) activity++;
        end
        n_vec++; if (activity !== 0) begin n_err++; $display("FAIL drop_idle: got %0d active cycles want 0", activity); end
    endtask

    task automatic test_random();
        bit r0, r1, o0, o1;
        logic [1:0] sel;
        int bias;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            sel  = 2'($urandom_range(1, 3));
            r0   = sel[0]; r1 = sel[1];
            bias = (t < 20) ? 75 : ((t < 40) ? 25 : 50);
            o0   = ($urandom_range(0, 99) < bias);
            o1   = ($urandom_range(0, 99) < bias);
            exec(r0, r1, o0, o1, 4'($urandom), 4'($urandom), win, ok, op, lat, vec, npush, npop, sdin);
            n_vec++; if (vec !== exp_vec(win, ok) || lat !== (ok ? 3 : 1)) begin
                n_err++; $display("FAIL rnd%0d_resp: got %b lat %0d want %b lat %0d", t, vec, lat, exp_vec(win, ok), ok ? 3 : 1); end
            n_vec++; if (npush !== int'(ok && op) || npop !== int'(ok && !op)) begin
                n_err++; $display("FAIL rnd%0d_strobe: got push=%0d pop=%0d want %0d/%0d", t, npush, npop, int'(ok && op), int'(ok && !op)); end
            n_vec++; if (Dout0 !== ref_dout[0] || Dout1 !== ref_dout[1]) begin
                n_err++; $display("FAIL rnd%0d_dout: got %h/%h want %h/%h", t, Dout0, Dout1, ref_dout[0], ref_dout[1]); end
            if (ok && op) begin
                n_vec++; if (sdin !== ref_q[ref_q.size() - 1]) begin
                    n_err++; $display("FAIL rnd%0d_sdin: got %h want %h", t, sdin, ref_q[ref_q.size() - 1]); end
            end
            release_reqs();
        end
    endtask

    initial begin
        test_reset();
        test_single_push_pop();
        test_contention();
        test_full_reject();
        test_empty_reject();
        test_reset_mid_op();
        test_req_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
